// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Write-back scheduler and scoreboard for a 32x32 register file.
//               Arbitrates the single register-file write port between the
//               ALU and load/memory write-back requesters (round-robin on
//               contention), tracks destination registers with writes in
//               flight, and stalls issue on RAW/WAW hazards.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               issue_*             - decode interface (issue_stall out)
//               alu_* / mem_*       - write-back requesters (valid/ready)
//               RegWrite, Write_register, Write_data - register file port
//               busy                - per-register pending-write scoreboard
//               spurious_wb         - sticky: write granted to a non-busy rd
// Options     : WB_BYPASS_EN adds bypass_hit1, bypass_hit2, bypass_data,
//               forwarding the write port to decode in the write cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_wr,
    output logic              issue_stall,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Write_register,
    output logic [DATA_W-1:0] Write_data,
    output logic [NREGS-1:0]  busy,
    output logic              spurious_wb
`ifdef WB_BYPASS_EN
    ,
    output logic              bypass_hit1,
    output logic              bypass_hit2,
    output logic [DATA_W-1:0] bypass_data
`endif
);

    localparam logic [ADDR_W-1:0] c_ZERO_REG = '0;

    logic [NREGS-1:0]  r_busy;
    logic              r_rr_ptr;        // 0: ALU wins next contention, 1: MEM
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_register;
    logic [DATA_W-1:0] r_write_data;
    logic              r_spurious;

    logic              w_alu_grant;
    logic              w_mem_grant;
    logic              w_grant;
    logic              w_contention;
    logic [ADDR_W-1:0] w_gnt_rd;
    logic [DATA_W-1:0] w_gnt_data;
    logic              w_accept;
    logic [NREGS-1:0]  w_set_mask;
    logic [NREGS-1:0]  w_clr_mask;

    // ------------------------------------------------------------------
    // Issue hazard check against the scoreboard
    // ------------------------------------------------------------------
    assign issue_stall = issue_valid &
                         (r_busy[issue_rs1] | r_busy[issue_rs2] |
                          (issue_wr & r_busy[issue_rd]));
    assign w_accept    = issue_valid & ~issue_stall;

    // ------------------------------------------------------------------
    // Round-robin arbitration. Grants are suppressed during reset so that
    // no requester sees a handshake that the reset is about to discard.
    // ------------------------------------------------------------------
    assign w_contention = alu_valid & mem_valid;
    assign w_alu_grant  = ~reset & alu_valid & (~mem_valid | ~r_rr_ptr);
    assign w_mem_grant  = ~reset & mem_valid & (~alu_valid |  r_rr_ptr);
    assign w_grant      = w_alu_grant | w_mem_grant;
    assign alu_ready    = w_alu_grant;
    assign mem_ready    = w_mem_grant;

    always_comb begin
        w_gnt_rd   = alu_rd;
        w_gnt_data = alu_data;
        if (w_mem_grant) begin
            w_gnt_rd   = mem_rd;
            w_gnt_data = mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard set/clear masks. Register 0 is never tracked.
    // ------------------------------------------------------------------
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_accept && issue_wr && (issue_rd != c_ZERO_REG)) begin
            w_set_mask[issue_rd] = 1'b1;
        end
        if (w_grant) begin
            w_clr_mask[w_gnt_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy           <= '0;
            r_rr_ptr         <= 1'b0;
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
            r_spurious       <= 1'b0;
        end else begin
            // Clear applied before set: a newly issued writer owns its rd.
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;

            if (w_contention) begin
                r_rr_ptr <= ~r_rr_ptr;
            end

            if (w_grant) begin
                r_reg_write      <= (w_gnt_rd != c_ZERO_REG);
                r_write_register <= w_gnt_rd;
                r_write_data     <= w_gnt_data;
                if ((w_gnt_rd != c_ZERO_REG) && !r_busy[w_gnt_rd]) begin
                    r_spurious <= 1'b1;
                end
            end else begin
                r_reg_write <= 1'b0;
            end
        end
    end

    assign busy           = r_busy;
    assign RegWrite       = r_reg_write;
    assign Write_register = r_write_register;
    assign Write_data     = r_write_data;
    assign spurious_wb    = r_spurious;

`ifdef WB_BYPASS_EN
    // Forward the in-progress register-file write to decode so that a read
    // of the register being written this cycle does not return stale data.
    assign bypass_hit1 = r_reg_write & (r_write_register == issue_rs1) &
                         (issue_rs1 != c_ZERO_REG);
    assign bypass_hit2 = r_reg_write & (r_write_register == issue_rs2) &
                         (issue_rs2 != c_ZERO_REG);
    assign bypass_data = r_write_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Self-checking bench for regfile_wb_scheduler. Directed
//               scenarios followed by randomized traffic, all compared to a
//               behavioural model of the scoreboard and write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              issue_valid, issue_wr;
    logic [ADDR_W-1:0] issue_rs1, issue_rs2, issue_rd;
    logic              issue_stall;
    logic              alu_valid, mem_valid;
    logic [ADDR_W-1:0] alu_rd, mem_rd;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              alu_ready, mem_ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] Write_register;
    logic [DATA_W-1:0] Write_data;
    logic [NREGS-1:0]  busy;
    logic              spurious_wb;
`ifdef WB_BYPASS_EN
    logic              bypass_hit1, bypass_hit2;
    logic [DATA_W-1:0] bypass_data;
`endif

    regfile_wb_scheduler #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rd       (issue_rd),
        .issue_wr       (issue_wr),
        .issue_stall    (issue_stall),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .mem_valid      (mem_valid),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .busy           (busy),
        .spurious_wb    (spurious_wb)
`ifdef WB_BYPASS_EN
        ,
        .bypass_hit1    (bypass_hit1),
        .bypass_hit2    (bypass_hit2),
        .bypass_data    (bypass_data)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    bit [31:0] m_busy;
    bit        m_mem_turn;    // set: MEM wins the next contention
    bit        m_rw;
    bit [4:0]  m_wreg;
    bit [31:0] m_wdata;
    bit        m_spur;
    bit        m_alu_rdy, m_mem_rdy;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Called just after a falling edge with inputs already driven; checks
    // combinational outputs, advances the model, then checks state after
    // the rising edge and returns on the next falling edge.
    task automatic step();
        bit        e_stall, granted;
        bit [4:0]  g_rd;
        bit [31:0] g_data, old_busy;
        #1;
        e_stall = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                                  (issue_wr && m_busy[issue_rd]));
        if (reset) begin
            m_alu_rdy = 0; m_mem_rdy = 0;
        end else if (alu_valid && mem_valid) begin
            m_alu_rdy = !m_mem_turn; m_mem_rdy = m_mem_turn;
        end else begin
            m_alu_rdy = alu_valid; m_mem_rdy = mem_valid;
        end
        chk_eq("issue_stall", issue_stall, e_stall);
        chk_eq("alu_ready", alu_ready, m_alu_rdy);
        chk_eq("mem_ready", mem_ready, m_mem_rdy);
`ifdef WB_BYPASS_EN
        chk_eq("bypass_hit1", bypass_hit1, m_rw && m_wreg == issue_rs1 && issue_rs1 != 0);
        chk_eq("bypass_hit2", bypass_hit2, m_rw && m_wreg == issue_rs2 && issue_rs2 != 0);
        chk_eq("bypass_data", bypass_data, m_wdata);
`endif
        if (reset) begin
            m_busy = 0; m_mem_turn = 0; m_rw = 0; m_wreg = 0; m_wdata = 0; m_spur = 0;
        end else begin
            old_busy = m_busy;
            granted  = m_alu_rdy || m_mem_rdy;
            g_rd     = m_alu_rdy ? alu_rd : mem_rd;
            g_data   = m_alu_rdy ? alu_data : mem_data;
            if (alu_valid && mem_valid) m_mem_turn = !m_mem_turn;
            if (granted) begin
                m_rw    = (g_rd != 0);
                m_wreg  = g_rd;
                m_wdata = g_data;
                if (g_rd != 0 && !old_busy[g_rd]) m_spur = 1;
                m_busy[g_rd] = 0;
            end else begin
                m_rw = 0;
            end
            if (issue_valid && !e_stall && issue_wr && issue_rd != 0) m_busy[issue_rd] = 1;
        end
        @(posedge clk);
        #1;
        chk_eq("RegWrite", RegWrite, m_rw);
        chk_eq("Write_register", Write_register, m_wreg);
        chk_eq("Write_data", Write_data, m_wdata);
        chk_eq("busy", busy, m_busy);
        chk_eq("spurious_wb", spurious_wb, m_spur);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 0; issue_valid = 0; issue_wr = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    task automatic do_issue(input bit [4:0] rs1, input bit [4:0] rs2,
                            input bit [4:0] rd, input bit wr);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_wr = wr;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; step(); step();
        reset = 0;
    endtask

    // Prefer a destination that is actually pending, occasionally a random one.
    function automatic bit [4:0] pick_rd();
        for (int t = 0; t < 8; t++) begin
            bit [4:0] r = 5'($urandom_range(1, 31));
            if (m_busy[r]) return r;
        end
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        bit alu_hold = 0, mem_hold = 0;
        idle_inputs();
        reset = 1;
        @(negedge clk);
        step(); step();
        reset = 0;

        // RAW stall on r3 released by the ALU write-back
        do_issue(0, 0, 3, 1); step();
        chk_eq("busy3_set", busy[3], 1'b1);
        do_issue(3, 0, 0, 0); step();
        chk_eq("stall_on_r3", issue_stall, 1'b1);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h15; step();
        alu_valid = 0; #1;
        chk_eq("r3_wr_data", Write_data, 32'h15);
        chk_eq("r3_unstall", issue_stall, 1'b0);
        step();
        idle_inputs();

        // Contention: grants alternate ALU, MEM, ALU, MEM
        do_issue(0, 0, 5, 1); step();
        do_issue(0, 0, 6, 1); step();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hA5;
        mem_valid = 1; mem_rd = 6; mem_data = 32'hB6;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_eq("rr_alu", alu_ready, (i % 2) == 0);
            chk_eq("rr_mem", mem_ready, (i % 2) == 1);
            step();
            chk_eq("rr_regwrite", RegWrite, 1'b1);
        end
        idle_inputs();
        do_reset();

        // Load to r0: handshake, no write, no error
        mem_valid = 1; mem_rd = 0; mem_data = 32'hFFFF_FFFF; step();
        mem_valid = 0;
        chk_eq("r0_no_write", RegWrite, 1'b0);
        chk_eq("r0_no_spur", spurious_wb, 1'b0);

        // Write to a non-busy register raises the sticky error
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77; step();
        alu_valid = 0;
        chk_eq("spur_set", spurious_wb, 1'b1);
        step(); step();
        chk_eq("spur_sticky", spurious_wb, 1'b1);

        // Bypass of the in-progress write to decode
        do_issue(0, 0, 4, 1); step();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 4; alu_data = 32'hAB; step();
        alu_valid = 0; do_issue(1, 4, 0, 0); step();
        idle_inputs();

        // Reset mid-operation discards the pending write to r9
        do_issue(0, 0, 9, 1); step();
        issue_valid = 0; reset = 1;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99; step();
        reset = 0; alu_valid = 0;
        chk_eq("rst_busy", busy, 32'h0);
        chk_eq("rst_spur", spurious_wb, 1'b0);

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 99) < 2);
            if (!alu_hold) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_rd = pick_rd(); alu_data = $urandom;
            end
            if (!mem_hold) begin
                mem_valid = ($urandom_range(0, 2) == 0);
                mem_rd = pick_rd(); mem_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_rs1 = 5'($urandom); issue_rs2 = 5'($urandom); issue_rd = 5'($urandom);
            issue_wr = $urandom_range(0, 1) == 1;
            // Keep a fresh issue off any register that may be written this cycle
            if ((alu_valid && issue_rd == alu_rd) || (mem_valid && issue_rd == mem_rd))
                issue_wr = 0;
            step();
            alu_hold = alu_valid && !m_alu_rdy;
            mem_hold = mem_valid && !m_mem_rdy;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Write-back scheduler and scoreboard for the 32x32 register file.
- Shares the single register-file write port between two write-back requesters, ALU and load/memory, using round-robin arbitration.
- Tracks which destination registers have writes in flight and stalls instruction issue on RAW/WAW hazards.
- Sits between the issue/decode stage, the execution units and the register file write port (RegWrite, Write_register, Write_data).

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- NREGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_rs1  in  ADDR_W  source register 1.
- issue_rs2  in  ADDR_W  source register 2.
- issue_rd  in  ADDR_W  destination register.
- issue_wr  in  1  instruction writes issue_rd.
- issue_stall  out  1  instruction not accepted; hold inputs.
- alu_valid  in  1  ALU write-back request.
- alu_rd  in  ADDR_W  ALU destination.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- mem_valid  in  1  load write-back request.
- mem_rd  in  ADDR_W  load destination.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request granted this cycle.
- RegWrite  out  1  register file write enable.
- Write_register  out  ADDR_W  register file write address.
- Write_data  out  DATA_W  register file write data.
- busy  out  NREGS  scoreboard; bit i set means a write to register i is pending.
- spurious_wb  out  1  sticky error flag.

Behaviour:
- Reset (synchronous): busy=0, RegWrite=0, Write_register=0, Write_data=0, spurious_wb=0, round-robin pointer=ALU. Reset mid-operation discards all pending state; requests asserted during reset are not granted.
- Issue is combinational: issue_stall = issue_valid & (busy[rs1] | busy[rs2] | (issue_wr & busy[rd])). No stall when issue_valid=0.
- Issue accept = issue_valid & ~issue_stall. On accept with issue_wr=1 and rd!=0, busy[rd] sets at the next edge. rd=0 never sets busy.
- Arbitration is combinational:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by the pointer is granted. The pointer then flips to the other source; it flips only on contention.
- A handshake completes when valid & ready.
- Write port is registered, latency 1: at the edge after a grant, RegWrite=1 (0 if the granted rd==0), Write_register=rd, Write_data=data. With no grant, RegWrite=0 and Write_register/Write_data hold their values.
- Scoreboard clear: busy[granted rd] clears at the same edge that loads RegWrite. Issue therefore unstalls in the cycle RegWrite is high.
- Same-edge set and clear of the same register cannot occur, because issue stalls on busy[rd]. Set/clear of different registers in the same cycle both take effect.
- A granted write whose rd has busy=0 (rd!=0) still writes, and sets spurious_wb. spurious_wb clears only on reset.
- Requesters must hold valid/rd/data until ready. ready is never asserted without valid.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds outputs bypass_hit1, bypass_hit2 (1 bit) and bypass_data (DATA_W).
  - bypass_hitN = RegWrite & (Write_register == issue_rsN) & (issue_rsN != 0).
  - bypass_data = Write_data.
  - Issue stall logic is unchanged; decode uses the bypass to avoid reading stale register-file data in the write cycle.
- Undefined: the ports and logic are absent. Decode must not read a register in the same cycle it is written.

Test Plan:
- Reset, then issue rd=3 with issue_wr=1 -> busy[3]=1 next cycle. Then issue rs1=3 -> issue_stall=1 until the cycle after alu_valid with alu_rd=3, alu_data=0x15 is granted; in that cycle RegWrite=1, Write_register=3, Write_data=0x15, busy[3]=0, issue_stall=0.
- alu_valid and mem_valid held high for 4 cycles (rd=5/6, busy set) -> grants alternate ALU, MEM, ALU, MEM, with RegWrite high on 4 consecutive cycles.
- mem_valid alone, rd=0, data=0xFFFFFFFF -> mem_ready=1, RegWrite=0 next cycle, busy unchanged, spurious_wb=0.
- Granted alu_rd=7 with busy[7]=0 -> write occurs, spurious_wb=1 and stays 1 until reset.
- Issue rd=9 accepted, assert reset one cycle later -> busy=0, RegWrite=0, pointer=ALU; an ALU request pending during reset gets no ready.
- WB_BYPASS_EN defined: RegWrite to register 4 with 0xAB while issue_rs2=4 -> bypass_hit2=1, bypass_data=0xAB, bypass_hit1=0.
